// File: rtl/reset_pkg.sv
// reset_pkg: types and helpers shared by the reset sequencer and its timer.
//   seq_state_e : sequencer state encoding (HOLD, WAIT, RUN, FAULT)
//   clog2w()    : bit width needed to hold values 0..n-1 (never less than 1)
//   FAIL_W      : width of the failing-domain index
package reset_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } seq_state_e;

    localparam int unsigned MAX_STAGES = 4;
    localparam int unsigned FAIL_W     = 2;

    function automatic int unsigned clog2w(input int unsigned n);
        int unsigned w;
        for (w = 1; (w < 32) && ((32'd1 << w) < n); w++) begin
        end
        return w;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// seq_timer: shared hold/timeout cycle counter.
//   clk_i  : clock (rising edge)
//   rst_i  : synchronous active-high reset, clears the count
//   clr_i  : synchronous clear, wins over enable
//   en_i   : count up by one this cycle
//   term_i : terminal-count value to compare against
//   tc_o   : high while the current count equals term_i
module seq_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] term_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == term_i);

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases STAGES reset domains one at a time.
// All domains are held for HOLD_CYCLES, then domain 0 is released; each
// further domain is released once the previous one acknowledges. A missing
// Ack within TIMEOUT_CYCLES, or any Ack loss, latches FAULT until SoftReq or
// Reset.
//   Clk       : clock (rising edge)
//   Reset     : synchronous active-high reset, overrides everything
//   SoftReq   : one-cycle request to restart the sequence from HOLD
//   Ack       : per-domain ready level
//   StageRst  : per-domain active-high reset (registered)
//   Busy      : high in HOLD or WAIT (registered)
//   Done      : high in RUN (registered)
//   Fault     : high in FAULT (registered)
//   FailStage : domain index of the most recent fault (registered)
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int unsigned STAGES         = 3,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              SoftReq,
    input  logic [STAGES-1:0] Ack,
    output logic [STAGES-1:0] StageRst,
    output logic              Busy,
    output logic              Done,
    output logic              Fault,
    output logic [1:0]        FailStage
);

    localparam int unsigned CNT_MAX =
        (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W = clog2w(CNT_MAX);
    localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TOUT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       LAST_K    = 2'(STAGES - 1);

    seq_state_e        state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [FAIL_W-1:0] fail_q, fail_d;
    logic [STAGES-1:0] rst_q, rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;

    logic              tmr_clr, tmr_en, tmr_tc;
    logic [CNT_W-1:0]  tmr_term;

    logic              ack_k;
    logic              low_lost, any_lost;
    logic [1:0]        low_idx, any_idx;

    seq_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .clr_i  (tmr_clr),
        .en_i   (tmr_en),
        .term_i (tmr_term),
        .tc_o   (tmr_tc)
    );

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        fail_d   = fail_q;
        tmr_clr  = 1'b0;
        tmr_en   = (state_q == ST_HOLD) || (state_q == ST_WAIT);
        tmr_term = (state_q == ST_HOLD) ? HOLD_TERM : TOUT_TERM;

        // Ack of the domain being waited on, lowest dropped Ack among the
        // already-released domains below K, and lowest dropped Ack overall.
        ack_k    = 1'b0;
        low_lost = 1'b0;
        low_idx  = '0;
        any_lost = 1'b0;
        any_idx  = '0;
        for (int unsigned j = 0; j < STAGES; j++) begin
            if (2'(j) == k_q) begin
                ack_k = Ack[j];
            end
            if (!Ack[j] && !any_lost) begin
                any_lost = 1'b1;
                any_idx  = 2'(j);
            end
            if (!Ack[j] && (2'(j) < k_q) && !low_lost) begin
                low_lost = 1'b1;
                low_idx  = 2'(j);
            end
        end

        case (state_q)
            ST_HOLD: begin
                if (tmr_tc) begin
                    state_d = ST_WAIT;
                    k_d     = '0;
                    tmr_clr = 1'b1;
                end
            end
            ST_WAIT: begin
                // A released domain losing Ack outranks progress; Ack on the
                // current domain outranks a timeout in the same cycle.
                if (low_lost) begin
                    state_d = ST_FAULT;
                    fail_d  = low_idx;
                end else if (ack_k) begin
                    if (k_q == LAST_K) begin
                        state_d = ST_RUN;
                    end else begin
                        k_d     = k_q + 2'd1;
                        tmr_clr = 1'b1;
                    end
                end else if (tmr_tc) begin
                    state_d = ST_FAULT;
                    fail_d  = k_q;
                end
            end
            ST_RUN: begin
                if (any_lost) begin
                    state_d = ST_FAULT;
                    fail_d  = any_idx;
                end
            end
            ST_FAULT: begin
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase

        if (SoftReq) begin
            state_d = ST_HOLD;
            k_d     = '0;
            tmr_clr = 1'b1;
        end

        // Outputs are decoded from the next state so they register on the
        // same edge as the state itself.
        rst_d   = '1;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        fault_d = 1'b0;
        case (state_d)
            ST_HOLD: begin
                busy_d = 1'b1;
            end
            ST_WAIT: begin
                busy_d = 1'b1;
                for (int unsigned j = 0; j < STAGES; j++) begin
                    rst_d[j] = (2'(j) > k_d);
                end
            end
            ST_RUN: begin
                rst_d  = '0;
                done_d = 1'b1;
            end
            default: begin
                fault_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_HOLD;
            k_q     <= '0;
            fail_q  <= '0;
            rst_q   <= '1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            fail_q  <= fail_d;
            rst_q   <= rst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    assign StageRst  = rst_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Fault     = fault_q;
    assign FailStage = fail_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: self-checking bench for reset_sequencer
// (STAGES=3, HOLD_CYCLES=16, TIMEOUT_CYCLES=1024). A behavioural model tracks
// how many domains have been released and how long the current wait has
// lasted; the DUT is compared against it every cycle, and directed scenarios
// pin absolute edge timing with literal expectations.
module tb_reset_sequencer;

    localparam int ST   = 3;
    localparam int HOLD = 16;
    localparam int TOUT = 1024;

    logic          Clk;
    logic          Reset;
    logic          SoftReq;
    logic [ST-1:0] Ack;
    logic [ST-1:0] StageRst;
    logic          Busy;
    logic          Done;
    logic          Fault;
    logic [1:0]    FailStage;

    int n_checks = 0;
    int n_pass   = 0;

    reset_sequencer #(
        .STAGES         (ST),
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .SoftReq   (SoftReq),
        .Ack       (Ack),
        .StageRst  (StageRst),
        .Busy      (Busy),
        .Done      (Done),
        .Fault     (Fault),
        .FailStage (FailStage)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- behavioural model ----------------
    int m_rel   = 0;   // domains released so far (0 while holding)
    int m_el    = 0;   // edges spent in the current hold/wait
    bit m_run   = 0;
    bit m_flt   = 0;
    int m_fail  = 0;
    bit m_valid = 0;
    int m_lo;

    function automatic int lowest_low(input logic [ST-1:0] v, input int limit);
        for (int j = 0; j < limit; j++) begin
            if (v[j] == 1'b0) return j;
        end
        return -1;
    endfunction

    always @(posedge Clk) begin
        if (Reset) begin
            m_rel = 0; m_el = 0; m_run = 0; m_flt = 0; m_fail = 0; m_valid = 1;
        end else if (SoftReq) begin
            m_rel = 0; m_el = 0; m_run = 0; m_flt = 0;
        end else if (m_flt) begin
        end else if (m_run) begin
            m_lo = lowest_low(Ack, ST);
            if (m_lo >= 0) begin m_run = 0; m_flt = 1; m_fail = m_lo; end
        end else if (m_rel == 0) begin
            m_el++;
            if (m_el == HOLD) begin m_rel = 1; m_el = 0; end
        end else begin
            m_lo = lowest_low(Ack, m_rel - 1);
            if (m_lo >= 0) begin
                m_flt = 1; m_fail = m_lo;
            end else if (Ack[m_rel-1]) begin
                if (m_rel == ST) m_run = 1;
                else begin m_rel++; m_el = 0; end
            end else begin
                m_el++;
                if (m_el == TOUT) begin m_flt = 1; m_fail = m_rel - 1; end
            end
        end
    end

    logic [ST-1:0] e_rst;
    logic          e_busy, e_done, e_fault;
    logic [1:0]    e_fail;

    always @(negedge Clk) begin
        if (m_valid) begin
            for (int j = 0; j < ST; j++) e_rst[j] = (m_flt || j >= m_rel);
            e_busy  = !m_flt && !m_run;
            e_done  = m_run;
            e_fault = m_flt;
            e_fail  = 2'(m_fail);
            n_checks++;
            if (StageRst !== e_rst || Busy !== e_busy || Done !== e_done ||
                Fault !== e_fault || FailStage !== e_fail) begin
                $display("FAIL model_cmp t=%0t got StageRst=%b Busy=%b Done=%b Fault=%b FailStage=%0d expected StageRst=%b Busy=%b Done=%b Fault=%b FailStage=%0d",
                         $time, StageRst, Busy, Done, Fault, FailStage,
                         e_rst, e_busy, e_done, e_fault, e_fail);
            end else begin
                n_pass++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int            dly[ST];      // Ack rises once a domain has been out of reset > dly edges
    int            low_cnt[ST];
    logic [ST-1:0] kill;         // forces Ack bits low
    bit            noise_en;     // random Ack on domains still in reset

    task automatic drive_ack();
        logic [ST-1:0] a;
        for (int k = 0; k < ST; k++) begin
            if (StageRst[k] === 1'b0) a[k] = (low_cnt[k] > dly[k]);
            else a[k] = noise_en && ($urandom_range(0, 3) == 0);
            if (kill[k]) a[k] = 1'b0;
        end
        Ack = a;
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
        for (int k = 0; k < ST; k++) begin
            if (StageRst[k] === 1'b0) low_cnt[k]++;
            else low_cnt[k] = 0;
        end
        drive_ack();
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        else n_pass++;
    endtask

    // Edge n counts from the first edge with Reset/SoftReq low.
    task automatic bringup(input int fs);
        for (int n = 1; n <= 40; n++) begin
            tick();
            case (n)
                15: chk("bring_e15", 32'(StageRst), 32'(3'b111));
                16: chk("bring_e16", 32'(StageRst), 32'(3'b110));
                21: chk("bring_e21", 32'(StageRst), 32'(3'b110));
                22: chk("bring_e22", 32'(StageRst), 32'(3'b100));
                27: chk("bring_e27", 32'(StageRst), 32'(3'b100));
                28: chk("bring_e28", 32'(StageRst), 32'(3'b000));
                33: begin
                    chk("bring_done33", 32'(Done), 32'd0);
                    chk("bring_busy33", 32'(Busy), 32'd1);
                end
                34: begin
                    chk("bring_done34", 32'(Done), 32'd1);
                    chk("bring_busy34", 32'(Busy), 32'd0);
                    chk("bring_fail34", 32'(FailStage), 32'(fs));
                end
                default: ;
            endcase
        end
    endtask

    task automatic soft_pulse();
        SoftReq = 1'b1;
        tick();
        SoftReq = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; SoftReq = 1'b0; Ack = '0; kill = '0; noise_en = 0;
        for (int k = 0; k < ST; k++) begin dly[k] = 5; low_cnt[k] = 0; end

        // Reset values
        tick(); tick(); tick();
        chk("rst_stagerst", 32'(StageRst), 32'(3'b111));
        chk("rst_busy", 32'(Busy), 32'd1);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_fault", 32'(Fault), 32'd0);
        chk("rst_failstage", 32'(FailStage), 32'd0);
        Reset = 1'b0;

        // Normal bring-up
        bringup(0);

        // Runtime loss of Ack[2]
        kill = 3'b100; drive_ack();
        tick();
        chk("loss_fault", 32'(Fault), 32'd1);
        chk("loss_failstage", 32'(FailStage), 32'd2);
        chk("loss_done", 32'(Done), 32'd0);
        chk("loss_stagerst", 32'(StageRst), 32'(3'b111));
        kill = '0; drive_ack();
        tick(); tick(); tick();
        chk("fault_sticky", 32'(Fault), 32'd1);

        // Restart from FAULT: identical timing, FailStage retained
        soft_pulse();
        chk("soft_stagerst", 32'(StageRst), 32'(3'b111));
        chk("soft_fault", 32'(Fault), 32'd0);
        chk("soft_failstage", 32'(FailStage), 32'd2);
        bringup(2);

        // Reset and SoftReq together mid-WAIT
        soft_pulse();
        repeat (25) tick();
        Reset = 1'b1; SoftReq = 1'b1;
        tick();
        chk("prio_stagerst", 32'(StageRst), 32'(3'b111));
        chk("prio_busy", 32'(Busy), 32'd1);
        chk("prio_done", 32'(Done), 32'd0);
        chk("prio_fault", 32'(Fault), 32'd0);
        chk("prio_failstage", 32'(FailStage), 32'd0);
        SoftReq = 1'b0;
        tick(); tick();
        Reset = 1'b0;
        bringup(0);

        // Timeout on domain 1
        kill = 3'b010;
        soft_pulse();
        for (int n = 1; n <= 1046; n++) begin
            tick();
            if (n == 22)   chk("tout_e22_stagerst", 32'(StageRst), 32'(3'b100));
            if (n == 1045) chk("tout_e1045_fault", 32'(Fault), 32'd0);
            if (n == 1046) begin
                chk("tout_fault", 32'(Fault), 32'd1);
                chk("tout_failstage", 32'(FailStage), 32'd1);
                chk("tout_stagerst", 32'(StageRst), 32'(3'b111));
            end
        end

        // Ack[0] arrives exactly at counter 1023
        kill = '0;
        dly[0] = 1023;
        soft_pulse();
        for (int n = 1; n <= 1040; n++) begin
            tick();
            if (n == 1039) chk("bnd_e1039_stagerst", 32'(StageRst), 32'(3'b110));
            if (n == 1040) begin
                chk("bnd_e1040_stagerst", 32'(StageRst), 32'(3'b100));
                chk("bnd_e1040_fault", 32'(Fault), 32'd0);
            end
        end
        dly[0] = 5;

        // Randomized episodes checked by the model
        noise_en = 1;
        for (int ep = 0; ep < 40; ep++) begin
            int len;
            kill = '0;
            for (int k = 0; k < ST; k++) dly[k] = $urandom_range(0, 8);
            len = 200;
            if (ep % 7 == 3) begin
                dly[$urandom_range(0, ST-1)] = $urandom_range(1018, 1030);
                len = 1150;
            end
            if ($urandom_range(0, 1) == 1) begin
                Reset = 1'b1; SoftReq = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 3)) tick();
                Reset = 1'b0; SoftReq = 1'b0;
            end else begin
                soft_pulse();
            end
            for (int c = 0; c < len; c++) begin
                kill = '0;
                if ($urandom_range(0, 49) == 0) kill[$urandom_range(0, ST-1)] = 1'b1;
                SoftReq = ($urandom_range(0, 399) == 0);
                Reset   = ($urandom_range(0, 599) == 0);
                drive_ack();
                tick();
            end
            Reset = 1'b0; SoftReq = 1'b0; kill = '0;
        end

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
